// File: rtl/branch_resolve_cycle.sv
// E-stage control-flow resolver: resolves JAL/JALR/branches, redirects fetch, squashes wrong-path loads.
// Optional perf counters enabled by defining BRANCH_RESOLVE_PERF_EN.
module branch_resolve_cycle #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  output logic [4:0]      A1D,
  output logic [4:0]      A2D,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            ValidE,
  output logic [XLEN-1:0] InstrE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            LinkWE,
  output logic [4:0]      LinkRdE,
`ifdef BRANCH_RESOLVE_PERF_EN
  output logic [31:0]     BrCntE,
  output logic [31:0]     BrTakenCntE,
  output logic [31:0]     SquashCntE,
`endif
  output logic [XLEN-1:0] LinkDataE
);

  localparam int unsigned SQ_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0] r_instr, r_pc, r_pc4, r_rd1, r_rd2;
  logic            r_valid;
  logic [SQ_W-1:0] r_sq_cnt;

  logic            w_is_jal, w_is_jalr, w_is_br, w_cond, w_taken;
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_j, w_target;
  logic [SQ_W-1:0] w_sq_next;

  assign A1D = InstrD[19:15];
  assign A2D = InstrD[24:20];

  // E-stage register; a load is valid only when no squash is pending after this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr  <= '0;
      r_pc     <= '0;
      r_pc4    <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_valid  <= 1'b0;
      r_sq_cnt <= '0;
    end else begin
      r_instr  <= InstrD;
      r_pc     <= PCD;
      r_pc4    <= PCPlus4D;
      r_rd1    <= RD1D;
      r_rd2    <= RD2D;
      r_valid  <= (w_sq_next == '0);
      r_sq_cnt <= w_sq_next;
    end
  end

  // Decode, condition evaluation, target and squash-count next state
  always_comb begin
    w_is_jal  = 1'b0;
    w_is_jalr = 1'b0;
    w_is_br   = 1'b0;
    w_cond    = 1'b0;
    w_target  = r_pc4;
    w_sq_next = '0;

    w_is_jal  = (r_instr[6:0] == OP_JAL);
    w_is_jalr = (r_instr[6:0] == OP_JALR);
    w_is_br   = (r_instr[6:0] == OP_BRANCH);

    w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

    unique case (r_instr[14:12])
      3'b000:  w_cond = (r_rd1 == r_rd2);
      3'b001:  w_cond = (r_rd1 != r_rd2);
      3'b100:  w_cond = ($signed(r_rd1) <  $signed(r_rd2));
      3'b101:  w_cond = ($signed(r_rd1) >= $signed(r_rd2));
      3'b110:  w_cond = (r_rd1 <  r_rd2);
      3'b111:  w_cond = (r_rd1 >= r_rd2);
      default: w_cond = 1'b0;
    endcase

    w_taken = r_valid & (w_is_jal | w_is_jalr | (w_is_br & w_cond));

    if (w_taken) begin
      if (w_is_jalr) w_target = (r_rd1 + w_imm_i) & ~XLEN'(1);
      else if (w_is_jal) w_target = r_pc + w_imm_j;
      else w_target = r_pc + w_imm_b;
    end

    // A redirect reloads the window; it also covers the load at the redirect edge
    if (w_taken) w_sq_next = SQ_W'(SQUASH_DEPTH);
    else if (r_sq_cnt != '0) w_sq_next = r_sq_cnt - SQ_W'(1);
  end

  assign PCSrcE    = w_taken;
  assign PCTargetE = w_target;
  assign ValidE    = r_valid;
  assign InstrE    = r_instr;
  assign PCE       = r_pc;
  assign PCPlus4E  = r_pc4;
  assign LinkWE    = r_valid & (w_is_jal | w_is_jalr) & (r_instr[11:7] != 5'd0);
  assign LinkRdE   = r_instr[11:7];
  assign LinkDataE = r_pc4;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] r_br_cnt, r_br_taken_cnt, r_squash_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt       <= '0;
      r_br_taken_cnt <= '0;
      r_squash_cnt   <= '0;
    end else begin
      if (r_valid & w_is_br) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_taken & w_is_br) r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
      if (w_sq_next != '0)   r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end

  assign BrCntE      = r_br_cnt;
  assign BrTakenCntE = r_br_taken_cnt;
  assign SquashCntE  = r_squash_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_cycle.sv
// Directed testbench for branch_resolve_cycle: redirects, squash window, links, mid-window reset.
module tb_branch_resolve_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
  logic [4:0]  A1D, A2D, LinkRdE;
  logic        PCSrcE, ValidE, LinkWE;
  logic [31:0] PCTargetE, InstrE, PCE, PCPlus4E, LinkDataE;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] BrCntE, BrTakenCntE, SquashCntE;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  branch_resolve_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RD1D(RD1D), .RD2D(RD2D), .A1D(A1D), .A2D(A2D), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ValidE(ValidE), .InstrE(InstrE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .LinkWE(LinkWE), .LinkRdE(LinkRdE),
`ifdef BRANCH_RESOLVE_PERF_EN
    .BrCntE(BrCntE), .BrTakenCntE(BrTakenCntE), .SquashCntE(SquashCntE),
`endif
    .LinkDataE(LinkDataE)
  );

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Present one D-side instruction, clock it into E, settle just after the edge
  task automatic load(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rd1, input logic [31:0] rd2);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; RD1D = rd1; RD2D = rd2;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    InstrD = enc_b(13'h020, 3'b000, 5'd1, 5'd2); PCD = 32'h10; PCPlus4D = 32'h14;
    RD1D = 32'd5; RD2D = 32'd5;
    #12;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL reset_pcsrc actual=%h required=0", PCSrcE); end
    checks++; if (PCTargetE !== 32'h0) begin errors++; $display("FAIL reset_target actual=%h required=0", PCTargetE); end
    checks++; if (ValidE !== 1'b0 || LinkWE !== 1'b0) begin errors++; $display("FAIL reset_valid_link actual=%b%b required=00", ValidE, LinkWE); end
    checks++; if (InstrE !== 32'h0 || PCE !== 32'h0) begin errors++; $display("FAIL reset_regs actual=%h/%h required=0/0", InstrE, PCE); end
    checks++; if (A1D !== 5'd1 || A2D !== 5'd2) begin errors++; $display("FAIL rs_addr actual=%0d/%0d required=1/2", A1D, A2D); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_beq();
    load(enc_b(13'h020, 3'b000, 5'd1, 5'd2), 32'h10, 32'd5, 32'd5);
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL beq_valid actual=%b required=1", ValidE); end
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_pcsrc actual=%b required=1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h30) begin errors++; $display("FAIL beq_target actual=%h required=00000030", PCTargetE); end
    load(NOP, 32'h14, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b0 || PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_sq1 actual=%b%b required=00", ValidE, PCSrcE); end
    load(NOP, 32'h18, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL beq_sq2 actual=%b required=0", ValidE); end
    load(NOP, 32'h30, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b1 || PCE !== 32'h30) begin errors++; $display("FAIL beq_target_in_e actual=%b/%h required=1/00000030", ValidE, PCE); end
  endtask

  task automatic test_bne();
    load(enc_b(13'h020, 3'b001, 5'd1, 5'd2), 32'h10, 32'd5, 32'd5);
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bne_pcsrc actual=%b required=0", PCSrcE); end
    checks++; if (PCTargetE !== 32'h14) begin errors++; $display("FAIL bne_target actual=%h required=00000014", PCTargetE); end
    load(NOP, 32'h14, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL bne_nosquash actual=%b required=1", ValidE); end
  endtask

  task automatic test_signed_unsigned();
    load(enc_b(13'h008, 3'b100, 5'd3, 5'd4), 32'h50, 32'hFFFF_FFFF, 32'd1);
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h58) begin errors++; $display("FAIL blt actual=%b/%h required=1/00000058", PCSrcE, PCTargetE); end
    load(NOP, 32'h54, 32'd0, 32'd0);
    load(NOP, 32'h58, 32'd0, 32'd0);
    load(enc_b(13'h008, 3'b110, 5'd3, 5'd4), 32'h58, 32'hFFFF_FFFF, 32'd1);
    checks++; if (ValidE !== 1'b1 || PCSrcE !== 1'b0 || PCTargetE !== 32'h5C) begin errors++; $display("FAIL bltu actual=%b%b/%h required=10/0000005c", ValidE, PCSrcE, PCTargetE); end
    // Backward branch: negative immediate
    load(enc_b(13'h1FF0, 3'b101, 5'd3, 5'd4), 32'h100, 32'd3, 32'd3);
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF0) begin errors++; $display("FAIL bge_back actual=%b/%h required=1/000000f0", PCSrcE, PCTargetE); end
    load(NOP, 32'h104, 32'd0, 32'd0);
    load(NOP, 32'h108, 32'd0, 32'd0);
    load(enc_b(13'h020, 3'b010, 5'd3, 5'd4), 32'hF0, 32'd3, 32'd3);
    checks++; if (ValidE !== 1'b1 || PCSrcE !== 1'b0) begin errors++; $display("FAIL f3_010 actual=%b%b required=10", ValidE, PCSrcE); end
  endtask

  task automatic test_jalr();
    load(enc_jalr(12'h004, 5'd2, 5'd1), 32'h40, 32'h103, 32'd0);
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h106) begin errors++; $display("FAIL jalr_target actual=%b/%h required=1/00000106", PCSrcE, PCTargetE); end
    checks++; if (LinkWE !== 1'b1 || LinkRdE !== 5'd1 || LinkDataE !== 32'h44) begin errors++; $display("FAIL jalr_link actual=%b/%0d/%h required=1/1/00000044", LinkWE, LinkRdE, LinkDataE); end
    load(NOP, 32'h44, 32'd0, 32'd0);
    load(NOP, 32'h48, 32'd0, 32'd0);
    load(enc_jalr(12'h004, 5'd2, 5'd0), 32'h106, 32'h103, 32'd0);
    checks++; if (PCSrcE !== 1'b1 || LinkWE !== 1'b0) begin errors++; $display("FAIL jalr_rd0 actual=%b%b required=10", PCSrcE, LinkWE); end
    load(NOP, 32'h10A, 32'd0, 32'd0);
    load(NOP, 32'h10E, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    load(enc_j(21'h000100, 5'd1), 32'h200, 32'd0, 32'd0);
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h300 || LinkWE !== 1'b1) begin errors++; $display("FAIL jal_first actual=%b/%h/%b required=1/00000300/1", PCSrcE, PCTargetE, LinkWE); end
    for (int i = 1; i <= 2; i++) begin
      load(enc_j(21'h000100, 5'd1), 32'h200 + 32'(4 * i), 32'd0, 32'd0);
      checks++; if (ValidE !== 1'b0 || PCSrcE !== 1'b0 || LinkWE !== 1'b0) begin errors++; $display("FAIL jal_slot%0d actual=%b%b%b required=000", i, ValidE, PCSrcE, LinkWE); end
    end
    load(enc_j(21'h000008, 5'd5), 32'h300, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b1 || PCSrcE !== 1'b1 || PCTargetE !== 32'h308 || LinkRdE !== 5'd5) begin errors++; $display("FAIL jal_after_window actual=%b%b/%h/%0d required=11/00000308/5", ValidE, PCSrcE, PCTargetE, LinkRdE); end
    load(NOP, 32'h304, 32'd0, 32'd0);
    load(NOP, 32'h308, 32'd0, 32'd0);
    load(NOP, 32'h308, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL window_end actual=%b required=1", ValidE); end
  endtask

  task automatic test_reset_mid_window();
    load(enc_j(21'h000040, 5'd1), 32'h400, 32'd0, 32'd0);
    load(NOP, 32'h404, 32'd0, 32'd0);
    #2 rst = 1'b0;
    #1;
    checks++; if (ValidE !== 1'b0 || PCSrcE !== 1'b0 || LinkWE !== 1'b0) begin errors++; $display("FAIL midrst_flags actual=%b%b%b required=000", ValidE, PCSrcE, LinkWE); end
    checks++; if (PCTargetE !== 32'h0 || InstrE !== 32'h0 || PCE !== 32'h0) begin errors++; $display("FAIL midrst_regs actual=%h/%h/%h required=0/0/0", PCTargetE, InstrE, PCE); end
    #2 rst = 1'b1;
    load(NOP, 32'h440, 32'd0, 32'd0);
    checks++; if (ValidE !== 1'b1 || PCE !== 32'h440) begin errors++; $display("FAIL postrst_valid actual=%b/%h required=1/00000440", ValidE, PCE); end
  endtask

`ifdef BRANCH_RESOLVE_PERF_EN
  task automatic test_perf();
    load(enc_b(13'h020, 3'b000, 5'd1, 5'd2), 32'h444, 32'd7, 32'd7);
    load(NOP, 32'h448, 32'd0, 32'd0);
    checks++; if (BrCntE !== 32'd1 || BrTakenCntE !== 32'd1 || SquashCntE !== 32'd1) begin errors++; $display("FAIL perf actual=%0d/%0d/%0d required=1/1/1", BrCntE, BrTakenCntE, SquashCntE); end
  endtask
`endif

  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_signed_unsigned();
    test_jalr();
    test_back_to_back();
    test_reset_mid_window();
`ifdef BRANCH_RESOLVE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_cycle.md
# branch_resolve_cycle

Decode/execute-side control-flow resolver for the 3-stage RISC-V pipeline. Captures the fetch stage's InstrD/PCD/PCPlus4D plus register operands into an E-stage register, resolves JAL/JALR/conditional branches, and drives PCSrcE/PCTargetE back to the fetch PC mux. Fetch has no flush input, so this block squashes the two wrong-path instructions that follow a taken redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SQUASH_DEPTH, 2, number of E-stage loads invalidated after a taken redirect.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- InstrD  in  32  instruction from fetch register.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RD1D, RD2D  in  32  register-file data for rs1/rs2 of InstrD.
- A1D, A2D  out  5  rs1 = InstrD[19:15], rs2 = InstrD[24:20]; combinational.
- PCSrcE  out  1  1 = fetch selects PCTargetE as next PC.
- PCTargetE  out  32  redirect target.
- ValidE  out  1  E-stage instruction is architecturally live.
- InstrE, PCE, PCPlus4E  out  32  E-stage copies.
- LinkWE  out  1  jump link write enable (JAL/JALR, valid, rd != 0).
- LinkRdE  out  5  InstrE[11:7].
- LinkDataE  out  32  equals PCPlus4E.

## Operation
- E register (InstrE, PCE, PCPlus4E, RD1E, RD2E, ValidE) loads every cycle from D-side inputs. No stall input.
- ValidE loads 1 unless squash counter sq_cnt != 0; then ValidE loads 0 and sq_cnt decrements.
- Decode on InstrE[6:0]: 1101111 JAL, 1100111 JALR, 1100011 BRANCH; anything else (including 0x00000000) is non-control.
- Immediates sign-extended to 32 bits: J-type {imm[20:1],0}, I-type imm[11:0], B-type {imm[12:1],0}.
- Targets (mod 2^32, carries discarded): JAL and BRANCH: PCE + imm. JALR: (RD1E + imm) & 0xFFFFFFFE.
- Branch condition by funct3 InstrE[14:12]: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. 010/011 never taken.
- taken = ValidE & (JAL | JALR | (BRANCH & cond)). PCSrcE = taken.
- PCTargetE is the computed target when taken, else PCPlus4E.
- On taken, sq_cnt loads SQUASH_DEPTH at the same edge, overriding any decrement.
- Control instructions with ValidE=0 are ignored: no redirect, no link write, no sq_cnt reload.
- Target alignment is not checked. Bit 1 is passed through.

## Timing
- Reset (rst=0, async): all E registers 0, ValidE=0, sq_cnt=0. Outputs during and after reset: PCSrcE=0, PCTargetE=0, LinkWE=0.
- D-to-E latency is 1 cycle. PCSrcE/PCTargetE are combinational from E registers and are valid in the same cycle the instruction sits in E.
- Redirect in cycle t:
  - Fetch PC = target at t+1.
  - E holds squashed instructions in t+1 and t+2 (PC_branch+4 and +8).
  - The target instruction enters E, valid, in t+3.
- Taken redirect in cycle t+3 immediately after a window is handled normally.
- Reset asserted mid-window clears sq_cnt. The first post-reset E load is valid.

## Configuration
- BRANCH_RESOLVE_PERF_EN defined: adds 32-bit wrapping counters and their outputs.
  - BrCntE counts valid BRANCH instructions.
  - BrTakenCntE counts taken BRANCH instructions.
  - SquashCntE counts squashed E loads.
  - All counters reset to 0.
- Undefined: counters and their ports are absent. Behaviour is otherwise identical.

## Test plan
- BEQ at PCE=0x10, imm=+0x20, RD1=RD2=5 -> PCSrcE=1, PCTargetE=0x30. ValidE=0 for the next 2 cycles, then 1 with PCE=0x30.
- BNE, RD1=RD2=5 -> PCSrcE=0, PCTargetE=PCPlus4E=0x14, no squash.
- BLT with RD1=0xFFFFFFFF, RD2=1 -> taken. BLTU with the same operands -> not taken.
- JALR at PCE=0x40, rd=1, RD1=0x103, imm=4 -> PCTargetE=0x106, LinkWE=1, LinkRdE=1, LinkDataE=0x44. With rd=0 -> LinkWE=0.
- Taken JAL followed by a JAL in each squash slot -> exactly one redirect, no link writes from the squashed slots.
- rst pulsed low during squash window -> all outputs 0 immediately. After release, the first instruction has ValidE=1.
